// File: rtl/pong_pkg.sv
// Shared geometry, speeds and phase encoding for the Pong controller.
// Centre positions are derived so the ball and paddles start mid-screen.
package pong_pkg;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BORDER       = 2;
  localparam int PADDLE_W     = 10;
  localparam int PADDLE_H     = 120;
  localparam int P1_X         = 20;
  localparam int P2_X         = 610;
  localparam int BALL_SIZE    = 8;
  localparam int BALL_SPEED   = 2;
  localparam int PADDLE_SPEED = 4;

  localparam int BALL_X0      = (SCREEN_W - BALL_SIZE) / 2;
  localparam int BALL_Y0      = (SCREEN_H - BALL_SIZE) / 2;
  localparam int PADDLE_Y0    = (SCREEN_H - PADDLE_H) / 2;
  localparam int PADDLE_Y_MIN = BORDER;
  localparam int PADDLE_Y_MAX = SCREEN_H - BORDER - PADDLE_H;

  typedef enum logic [1:0] {
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } game_state_t;
endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: steps by PADDLE_SPEED per frame tick, clamped inside the borders.
// recenter wins over motion so a game restart always lands at the start height.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       en,
  input  logic       recenter,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);
  localparam logic signed [10:0] STEP  = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] Y_MIN = 11'(PADDLE_Y_MIN);
  localparam logic signed [10:0] Y_MAX = 11'(PADDLE_Y_MAX);

  logic signed [10:0] y_step;
  logic [9:0]         y_next;

  always_comb begin
    y_step = $signed({1'b0, y});
    if (up && !dn)
      y_step = y_step - STEP;
    else if (dn && !up)
      y_step = y_step + STEP;

    if (y_step < Y_MIN)
      y_next = Y_MIN[9:0];
    else if (y_step > Y_MAX)
      y_next = Y_MAX[9:0];
    else
      y_next = y_step[9:0];
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      y <= 10'(PADDLE_Y0);
    else if (tick) begin
      if (recenter)
        y <= 10'(PADDLE_Y0);
      else if (en)
        y <= y_next;
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong controller: all motion, scoring and phase changes happen on the
// V_visible falling edge. Define PONG_AI_P2_EN to let P2 chase the ball on its own.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       V_visible,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over
);
  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_CNT  = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  localparam logic signed [10:0] V_STEP   = 11'(BALL_SPEED);
  localparam logic signed [10:0] BSZ      = 11'(BALL_SIZE);
  localparam logic signed [10:0] PH       = 11'(PADDLE_H);
  localparam logic signed [10:0] TOP_Y    = 11'(BORDER);
  localparam logic signed [10:0] BOT_Y    = 11'(SCREEN_H - BORDER - BALL_SIZE);
  localparam logic signed [10:0] LEFT_X   = 11'(BORDER);
  localparam logic signed [10:0] RIGHT_X  = 11'(SCREEN_W - BORDER - BALL_SIZE);
  localparam logic signed [10:0] P1_LEFT  = 11'(P1_X);
  localparam logic signed [10:0] P1_FACE  = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0] P2_LEFT  = 11'(P2_X);
  localparam logic signed [10:0] P2_RIGHT = 11'(P2_X + PADDLE_W);
  localparam logic signed [10:0] P2_FACE  = 11'(P2_X - BALL_SIZE);

  logic               vvis_reg;
  logic               tick;
  game_state_t        state;
  logic [CNT_W-1:0]   frame_cnt;
  logic               vx_neg;
  logic               vy_neg;
  logic               serve_left;
  logic signed [10:0] nx, ny, by, p1s, p2s;
  logic               hit_p1, hit_p2, miss_l, miss_r;
  logic [1:0]         pad_up, pad_dn;
  logic [9:0]         pad_y [2];

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      vvis_reg <= 1'b0;
    else
      vvis_reg <= V_visible;
  end

  assign tick = vvis_reg && !V_visible;

  assign pad_up[0] = p1_up;
  assign pad_dn[0] = p1_dn;
`ifdef PONG_AI_P2_EN
  // Compare ball centre against a +/-4 px dead band around the paddle centre.
  assign pad_up[1] = ({1'b0, ball_y} + 11'(BALL_SIZE / 2)) < ({1'b0, p2_y} + 11'(PADDLE_H / 2 - 4));
  assign pad_dn[1] = ({1'b0, ball_y} + 11'(BALL_SIZE / 2)) > ({1'b0, p2_y} + 11'(PADDLE_H / 2 + 4));
  logic unused_p2_buttons;
  assign unused_p2_buttons = p2_up ^ p2_dn;
`else
  assign pad_up[1] = p2_up;
  assign pad_dn[1] = p2_dn;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
      pong_paddle_ctrl u_paddle (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .en        (state != ST_OVER),
        .recenter  ((state == ST_OVER) && serve),
        .up        (pad_up[gi]),
        .dn        (pad_dn[gi]),
        .y         (pad_y[gi])
      );
    end
  endgenerate

  assign p1_y = pad_y[0];
  assign p2_y = pad_y[1];

  // Overlap tests use the paddle heights registered before this tick.
  assign by  = $signed({1'b0, ball_y});
  assign p1s = $signed({1'b0, p1_y});
  assign p2s = $signed({1'b0, p2_y});
  assign nx  = $signed({1'b0, ball_x}) + (vx_neg ? -V_STEP : V_STEP);
  assign ny  = by + (vy_neg ? -V_STEP : V_STEP);

  assign hit_p1 = vx_neg && (nx <= P1_FACE) && (nx + BSZ > P1_LEFT) &&
                  (by + BSZ > p1s) && (by < p1s + PH);
  assign hit_p2 = !vx_neg && (nx + BSZ >= P2_LEFT) && (nx < P2_RIGHT) &&
                  (by + BSZ > p2s) && (by < p2s + PH);
  assign miss_l = (nx < LEFT_X) && !hit_p1;
  assign miss_r = (nx > RIGHT_X) && !hit_p2;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SERVE;
      frame_cnt  <= '0;
      ball_x     <= 10'(BALL_X0);
      ball_y     <= 10'(BALL_Y0);
      vx_neg     <= 1'b0;
      vy_neg     <= 1'b0;
      serve_left <= 1'b0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      game_over  <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_SERVE: begin
          if (serve || (frame_cnt == SERVE_CNT)) begin
            state     <= ST_PLAY;
            frame_cnt <= '0;
            vx_neg    <= serve_left;
            vy_neg    <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_l) begin
            state      <= ST_POINT;
            serve_left <= 1'b1;
            if (p2_score != WIN)
              p2_score <= p2_score + 4'd1;
          end else if (miss_r) begin
            state      <= ST_POINT;
            serve_left <= 1'b0;
            if (p1_score != WIN)
              p1_score <= p1_score + 4'd1;
          end else begin
            if (hit_p1) begin
              ball_x <= P1_FACE[9:0];
              vx_neg <= 1'b0;
            end else if (hit_p2) begin
              ball_x <= P2_FACE[9:0];
              vx_neg <= 1'b1;
            end else begin
              ball_x <= nx[9:0];
            end
            if (ny < TOP_Y) begin
              ball_y <= TOP_Y[9:0];
              vy_neg <= 1'b0;
            end else if (ny > BOT_Y) begin
              ball_y <= BOT_Y[9:0];
              vy_neg <= 1'b1;
            end else begin
              ball_y <= ny[9:0];
            end
          end
        end
        ST_POINT: begin
          if (frame_cnt == POINT_LAST) begin
            frame_cnt <= '0;
            ball_x    <= 10'(BALL_X0);
            ball_y    <= 10'(BALL_Y0);
            if ((p1_score == WIN) || (p2_score == WIN)) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_SERVE;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: begin
          if (serve) begin
            state     <= ST_SERVE;
            frame_cnt <= '0;
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            game_over <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a frame-level reference model pushes the expected
// snapshot per tick into a queue, popped and compared one cycle after the DUT tick.
module tb_pong_game_ctrl;
  localparam int WIN     = 9;
  localparam int SERVE_F = 60;
  localparam int POINT_F = 30;
  localparam int S_SERVE = 0, S_PLAY = 1, S_POINT = 2, S_OVER = 3;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  logic V_visible = 1'b0;
  logic p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0, serve = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] p1_score, p2_score;
  logic       game_over;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE_F), .POINT_FRAMES(POINT_F)) dut (
    .pixel_clk (pixel_clk), .rst_n (rst_n), .V_visible (V_visible),
    .p1_up (p1_up), .p1_dn (p1_dn), .p2_up (p2_up), .p2_dn (p2_dn), .serve (serve),
    .ball_x (ball_x), .ball_y (ball_y), .p1_y (p1_y), .p2_y (p2_y),
    .p1_score (p1_score), .p2_score (p2_score), .game_over (game_over)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [9:0] bx, by, p1, p2;
    logic [3:0] s1, s2;
    logic       go;
  } snap_t;

  snap_t exp_q[$];
  snap_t last_exp;
  int n_assert = 0, n_fail = 0;
  int m_state, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_cnt;
  bit m_go, m_serve_left;
  int tick_no = 0, pts_p1 = 0, pts_p2 = 0, hits_p1 = 0, hits_p2 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s tick %0d: observed %0d, expected %0d", tag, tick_no, obs, exp);
    end
  endtask

  task automatic check_snap(input string tag, input snap_t e);
    check({tag, ".ball_x"}, 32'(ball_x), 32'(e.bx));
    check({tag, ".ball_y"}, 32'(ball_y), 32'(e.by));
    check({tag, ".p1_y"}, 32'(p1_y), 32'(e.p1));
    check({tag, ".p2_y"}, 32'(p2_y), 32'(e.p2));
    check({tag, ".p1_score"}, 32'(p1_score), 32'(e.s1));
    check({tag, ".p2_score"}, 32'(p2_score), 32'(e.s2));
    check({tag, ".game_over"}, 32'(game_over), 32'(e.go));
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.bx = 10'(m_bx); s.by = 10'(m_by); s.p1 = 10'(m_p1); s.p2 = 10'(m_p2);
    s.s1 = 4'(m_s1); s.s2 = 4'(m_s2); s.go = m_go;
    return s;
  endfunction

  function automatic int clamp_pad(input int v);
    if (v < 2) return 2;
    if (v > 358) return 358;
    return v;
  endfunction

  task automatic model_reset();
    m_state = S_SERVE; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_p1 = 180; m_p2 = 180; m_s1 = 0; m_s2 = 0; m_cnt = 0;
    m_go = 1'b0; m_serve_left = 1'b0;
  endtask

  task automatic model_tick(input logic u1, input logic d1, input logic u2,
                            input logic d2, input logic srv);
    int np1, np2, nx, ny;
    bit h1, h2;
`ifdef PONG_AI_P2_EN
    u2 = (m_by + 4) < (m_p2 + 56);
    d2 = (m_by + 4) > (m_p2 + 64);
`endif
    np1 = m_p1;
    np2 = m_p2;
    if (m_state != S_OVER) begin
      np1 = clamp_pad(m_p1 + ((u1 && !d1) ? -4 : ((d1 && !u1) ? 4 : 0)));
      np2 = clamp_pad(m_p2 + ((u2 && !d2) ? -4 : ((d2 && !u2) ? 4 : 0)));
    end
    case (m_state)
      S_SERVE: begin
        if (srv || m_cnt == SERVE_F) begin
          m_state = S_PLAY; m_cnt = 0; m_vy = 2;
          m_vx = m_serve_left ? -2 : 2;
        end else m_cnt++;
      end
      S_PLAY: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        h1 = (m_vx < 0) && (nx <= 30) && (nx + 8 > 20) && (m_by + 8 > m_p1) && (m_by < m_p1 + 120);
        h2 = (m_vx > 0) && (nx + 8 >= 610) && (nx < 620) && (m_by + 8 > m_p2) && (m_by < m_p2 + 120);
        if (nx < 2 && !h1) begin
          if (m_s2 < WIN) m_s2++;
          m_state = S_POINT; m_serve_left = 1'b1; pts_p2++;
        end else if (nx > 630 && !h2) begin
          if (m_s1 < WIN) m_s1++;
          m_state = S_POINT; m_serve_left = 1'b0; pts_p1++;
        end else begin
          if (h1) begin m_bx = 30; m_vx = 2; hits_p1++; end
          else if (h2) begin m_bx = 602; m_vx = -2; hits_p2++; end
          else m_bx = nx;
          if (ny < 2) begin m_by = 2; m_vy = 2; end
          else if (ny > 470) begin m_by = 470; m_vy = -2; end
          else m_by = ny;
        end
      end
      S_POINT: begin
        m_cnt++;
        if (m_cnt == POINT_F) begin
          m_cnt = 0; m_bx = 316; m_by = 236;
          if (m_s1 == WIN || m_s2 == WIN) begin m_state = S_OVER; m_go = 1'b1; end
          else m_state = S_SERVE;
        end
      end
      default: begin
        if (srv) begin
          m_s1 = 0; m_s2 = 0; np1 = 180; np2 = 180;
          m_state = S_SERVE; m_go = 1'b0;
        end
      end
    endcase
    m_p1 = np1;
    m_p2 = np2;
  endtask

  // One frame: visible for hi_cycles, then the falling edge produces the tick.
  task automatic frame(input int hi_cycles);
    snap_t e;
    V_visible = 1'b1;
    for (int i = 0; i < hi_cycles; i++) begin
      @(posedge pixel_clk); #1;
      if (i == hi_cycles - 1) check_snap("hold", last_exp);
    end
    V_visible = 1'b0;
    tick_no++;
    model_tick(p1_up, p1_dn, p2_up, p2_dn, serve);
    exp_q.push_back(model_snap());
    @(posedge pixel_clk); #1;
    e = exp_q.pop_front();
    check_snap("tick", e);
    last_exp = e;
    @(posedge pixel_clk); #1;
  endtask

  // mode 0 idle, 3 chase the ball, 4 run to the half away from the ball
  task automatic drive_pad(input int mode, input int py, output logic u, output logic d);
    int c;
    c = m_by + 4;
    u = 1'b0;
    d = 1'b0;
    if (mode == 3) begin
      u = (c < py + 56);
      d = (c > py + 64);
    end else if (mode == 4) begin
      if (c < 240) d = 1'b1;
      else u = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pt, prev;
    model_reset();
    last_exp = model_snap();
    rst_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_snap("reset", last_exp);
    rst_n = 1'b1;
    @(posedge pixel_clk); #1;

    for (int t = 1; t <= 62; t++) begin
      p1_up = (t <= 50);
      frame(3);
      if (t == 1)  check("p1_up_first", 32'(p1_y), 32'd176);
      if (t == 45) check("p1_up_clamp", 32'(p1_y), 32'd2);
      if (t == 50) check("p1_up_stay", 32'(p1_y), 32'd2);
      if (t == 61) check("serve_park_x", 32'(ball_x), 32'd316);
      if (t == 62) begin
        check("serve_move_x", 32'(ball_x), 32'd318);
        check("serve_move_y", 32'(ball_y), 32'd238);
      end
    end
    $display("auto serve phase done at tick %0d", tick_no);

    pt = 0;
    for (int n = 0; n < 8000 && m_state != S_OVER; n++) begin
      prev = m_state;
      if (pt == 1) begin
        drive_pad(4, m_p1, p1_up, p1_dn);
        drive_pad(3, m_p2, p2_up, p2_dn);
      end else begin
        drive_pad(3, m_p1, p1_up, p1_dn);
        drive_pad(4, m_p2, p2_up, p2_dn);
      end
      serve = (m_state == S_SERVE) || (m_state == S_POINT && tick_no % 4 == 0);
      frame(3);
      if (prev == S_PLAY && m_state == S_POINT) begin
        pt++;
        $display("point %0d at tick %0d: score %0d-%0d", pt, tick_no, m_s1, m_s2);
      end
    end
    check("game_over_reached", 32'(game_over), 32'd1);
    check("winner_at_limit", 32'(p1_score == 4'(WIN) || p2_score == 4'(WIN)), 32'd1);
    $display("rally stats: p1 hits %0d, p2 hits %0d, p1 pts %0d, p2 pts %0d",
             hits_p1, hits_p2, pts_p1, pts_p2);

    serve = 1'b0; p1_up = 1'b0; p1_dn = 1'b1; p2_up = 1'b1; p2_dn = 1'b0;
    repeat (3) frame(3);
    check("over_hold", 32'(game_over), 32'd1);
    serve = 1'b1;
    frame(3);
    check("restart_s1", 32'(p1_score), 32'd0);
    check("restart_s2", 32'(p2_score), 32'd0);
    check("restart_p1", 32'(p1_y), 32'd180);
    check("restart_p2", 32'(p2_y), 32'd180);
    check("restart_go", 32'(game_over), 32'd0);

    serve = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p1_up = 1'b1;
    V_visible = 1'b0;
    repeat (30) @(posedge pixel_clk);
    #1;
    check_snap("stuck_low", last_exp);
    frame(40);
    $display("stuck V_visible phase done at tick %0d", tick_no);

    serve = 1'b1;
    frame(3);
    serve = 1'b0;
    repeat (5) frame(3);
    check("moved_before_reset", 32'(ball_x != 10'd316), 32'd1);
    V_visible = 1'b1;
    @(posedge pixel_clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    last_exp = model_snap();
    check_snap("async_reset", last_exp);
    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    repeat (2) frame(3);
    check("post_reset_p1", 32'(p1_y), 32'd172);
    serve = 1'b1;
    frame(3);
    serve = 1'b0;
    repeat (3) frame(3);
    $display("reset phase done at tick %0d, queue depth %0d", tick_no, exp_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
